// File: rtl/ftdi_fifo_responder_pkg.sv
// Shared types and constants for the FTDI 245-FIFO responder and the host interface.
package ftdi_pkg;

  localparam int BYTE_W = 8;

  // Strobes (rd/wr) are active low on the FT232H pins.
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } ftdi_resp_state_t;

endpackage

// File: rtl/ftdi_fifo_responder_fifo.sv
// Synchronous show-ahead FIFO; full/empty derive from the occupancy count.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous push and pop leave the occupancy unchanged.
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// FTDI-side stand-in for the FT232H async 245 FIFO: answers host rd/wr strobes
// from a usb_tx queue and stores host writes in a usb_rx queue.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_ftdi_rd,
  input  logic                   i_ftdi_wr,
  input  logic [BYTE_W-1:0]      i_adbus_in,
  output logic                   o_rxf,
  output logic                   o_txe,
  output logic [BYTE_W-1:0]      o_adbus_out,
  output logic                   o_adbus_oe,
  input  logic                   i_usb_push,
  input  logic [BYTE_W-1:0]      i_usb_data,
  output logic                   o_usb_full,
  input  logic                   i_usb_pop,
  output logic [BYTE_W-1:0]      o_usb_q,
  output logic                   o_usb_empty,
  output logic [$clog2(DEPTH):0] o_tx_count,
  output logic [$clog2(DEPTH):0] o_rx_count,
  output logic                   o_proto_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  ftdi_resp_state_t r_state;
  ftdi_resp_state_t w_state_nxt;

  logic              r_rd_q;
  logic              r_wr_q;
  logic [BYTE_W-1:0] r_adbus_out;
  logic [BYTE_W-1:0] r_wr_byte;
  logic              r_wr_discard;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_proto_err;

  logic              w_rd_fall;
  logic              w_rd_rise;
  logic              w_wr_fall;
  logic              w_wr_rise;
  logic              w_tx_pop;
  logic              w_rx_push;
  logic [BYTE_W-1:0] w_tx_dout;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_rx_full;
  logic              w_violation;

  assign w_rd_fall = (r_rd_q == STROBE_IDLE)   && (i_ftdi_rd == STROBE_ACTIVE);
  assign w_rd_rise = (r_rd_q == STROBE_ACTIVE) && (i_ftdi_rd == STROBE_IDLE);
  assign w_wr_fall = (r_wr_q == STROBE_IDLE)   && (i_ftdi_wr == STROBE_ACTIVE);
  assign w_wr_rise = (r_wr_q == STROBE_ACTIVE) && (i_ftdi_wr == STROBE_IDLE);

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_usb_tx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_push  (i_usb_push),
    .i_pop   (w_tx_pop),
    .i_din   (i_usb_data),
    .o_dout  (w_tx_dout),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (o_tx_count)
  );

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_usb_rx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_push  (w_rx_push),
    .i_pop   (i_usb_pop),
    .i_din   (r_wr_byte),
    .o_dout  (o_usb_q),
    .o_full  (w_rx_full),
    .o_empty (o_usb_empty),
    .o_count (o_rx_count)
  );

  assign o_usb_full  = w_tx_full;
  assign o_adbus_out = r_adbus_out;
  assign o_proto_err = r_proto_err;

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    o_rxf       = 1'b1;
    o_txe       = 1'b1;
    o_adbus_oe  = 1'b0;
    case (r_state)
      IDLE: begin
        o_rxf = w_tx_empty;
        o_txe = w_rx_full;
        if (w_rd_fall) begin
          w_state_nxt = READ;
          w_tx_pop    = ~w_tx_empty;
        end else if (w_wr_fall) begin
          w_state_nxt = WRITE;
        end
      end
      READ: begin
        o_adbus_oe = 1'b1;
        if (w_rd_rise) w_state_nxt = GAP;
      end
      WRITE: begin
        if (w_wr_rise) begin
          w_state_nxt = GAP;
          w_rx_push   = ~r_wr_discard;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_reset) begin
      o_rxf      = 1'b1;
      o_txe      = 1'b1;
      o_adbus_oe = 1'b0;
      w_tx_pop   = 1'b0;
      w_rx_push  = 1'b0;
    end
  end

  assign w_violation = ((r_state == IDLE) && w_rd_fall && w_tx_empty)
                     | ((r_state == IDLE) && !w_rd_fall && w_wr_fall && w_rx_full)
                     | ((r_state == GAP) && (w_rd_fall || w_wr_fall))
                     | ((i_ftdi_rd == STROBE_ACTIVE) && (i_ftdi_wr == STROBE_ACTIVE));

  // Edge detectors keep tracking the pins through clear so a strobe already low
  // when clear lands is not mistaken for a new fall.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_rd_q       <= STROBE_IDLE;
      r_wr_q       <= STROBE_IDLE;
      r_adbus_out  <= '0;
      r_wr_byte    <= '0;
      r_wr_discard <= 1'b0;
      r_gap_cnt    <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_rd_q <= i_ftdi_rd;
      r_wr_q <= i_ftdi_wr;
      if (w_violation) r_proto_err <= 1'b1;
      if (i_clear) begin
        r_state      <= IDLE;
        r_adbus_out  <= '0;
        r_wr_byte    <= '0;
        r_wr_discard <= 1'b0;
        r_gap_cnt    <= '0;
      end else begin
        r_state <= w_state_nxt;
        if ((r_state == IDLE) && w_rd_fall)
          r_adbus_out <= w_tx_empty ? '0 : w_tx_dout;
        if ((i_ftdi_wr == STROBE_ACTIVE) &&
            ((r_state == WRITE) || ((r_state == IDLE) && w_wr_fall && !w_rd_fall)))
          r_wr_byte <= i_adbus_in;
        if ((r_state == IDLE) && w_wr_fall && !w_rd_fall)
          r_wr_discard <= w_rx_full;
        if ((r_state != GAP) && (w_state_nxt == GAP))
          r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        else if ((r_state == GAP) && (r_gap_cnt != '0))
          r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

endmodule
